uart_receiver: RTL and testbench

- UART receive path; companion to the transmitter on the same 16x oversampling uart_clk.
- Samples serial input uart_rxd, deframes 8N1 frames (start, 8 data LSB-first, 1 stop) and pushes each good byte into the RX FIFO through a single-cycle write strobe.
- Flags framing errors and FIFO overruns as single-cycle pulses for the status/interrupt logic.

---
 rtl/uart_receiver_if.sv | 11 +
 rtl/uart_receiver.sv | 107 ++++++++++
 tb/tb_uart_receiver.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_receiver_if.sv
// RX FIFO write side plus receive status pulses of the UART receiver.
interface uart_receiver_if;
  logic       rf_full;
  logic       rf_wrreq;
  logic [7:0] rf_data;
  logic       frame_err;
  logic       overrun;

  modport master (input rf_full, output rf_wrreq, rf_data, frame_err, overrun);
  modport slave  (output rf_full, input rf_wrreq, rf_data, frame_err, overrun);
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver on an OS x baud clock: 2-flop sync, 2-of-3 mid-bit voting,
// one FIFO write strobe per good byte, framing-error and overrun pulses.
module uart_receiver #(
  parameter int OS = 16,
  parameter int CW = 8
) (
  input  logic        uart_clk,
  input  logic        rst_n,
  input  logic        uart_rxd,
  uart_receiver_if.master rf
);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;

  localparam logic [CW-1:0] FIRST_DEC = CW'(OS/2 + 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(8*OS + OS/2 + 1);
  localparam logic [CW-1:0] STEP      = CW'(OS);

  logic          rxd_meta, rxd_s;
  logic [1:0]    hist;
  logic [2:0]    state;
  logic [CW-1:0] cnt, dec_at;
  logic [7:0]    shreg;
  logic          maj, decide;

  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
      hist     <= 2'b11;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_s    <= rxd_meta;
      hist     <= {hist[0], rxd_s};
    end
  end

  // hist holds rxd_s from cnt-2 and cnt-1, so the vote lands on cnt = decision cycle
  assign maj    = (hist[1] & hist[0]) | (hist[1] & rxd_s) | (hist[0] & rxd_s);
  assign decide = (cnt == dec_at);

  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      dec_at       <= FIRST_DEC;
      shreg        <= 8'h00;
      rf.rf_wrreq  <= 1'b0;
      rf.rf_data   <= 8'h00;
      rf.frame_err <= 1'b0;
      rf.overrun   <= 1'b0;
    end else begin
      rf.rf_wrreq  <= 1'b0;
      rf.frame_err <= 1'b0;
      rf.overrun   <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxd_s) begin
            state  <= START;
            cnt    <= '0;
            dec_at <= FIRST_DEC;
          end
        end
        START: begin
          cnt <= cnt + 1'b1;
          if (decide) begin
            dec_at <= dec_at + STEP;
            state  <= maj ? IDLE : DATA;
          end
        end
        DATA: begin
          cnt <= cnt + 1'b1;
          if (decide) begin
            shreg  <= {maj, shreg[7:1]};
            dec_at <= dec_at + STEP;
            if (dec_at == LAST_DATA) state <= STOP;
          end
        end
        STOP: begin
          cnt <= cnt + 1'b1;
          if (decide) begin
            if (!maj) begin
              rf.frame_err <= 1'b1;
              state        <= WAIT_IDLE;
            end else begin
              // back to IDLE mid stop bit so the next start edge is not missed
              state <= IDLE;
              if (rf.rf_full) begin
                rf.overrun <= 1'b1;
              end else begin
                rf.rf_data  <= shreg;
                rf.rf_wrreq <= 1'b1;
              end
            end
          end
        end
        WAIT_IDLE: begin
          if (rxd_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed vector table, hand sequences
// for glitch/break/back-to-back/reset, then randomized frames against a frame-level model.
module tb_uart_receiver;
  localparam int OS   = 16;
  localparam int LAT  = 157;  // pin-low drive edge to rf_wrreq visible: 3 to START + 154
  localparam int K_NONE = 0, K_WR = 1, K_FE = 2, K_OV = 3;

  logic uart_clk = 1'b0;
  logic rst_n    = 1'b0;
  logic uart_rxd = 1'b1;
  uart_receiver_if rif();

  uart_receiver #(.OS(OS), .CW(8)) dut (
    .uart_clk (uart_clk),
    .rst_n    (rst_n),
    .uart_rxd (uart_rxd),
    .rf       (rif.master)
  );

  always #5 uart_clk = ~uart_clk;

  typedef struct {
    int         kind;
    logic [7:0] data;
    longint     cyc;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    int         b4;       // bit period in quarter uart_clk cycles
    bit         stop_ok;
    bit         full;
    int         glitch;   // drive cycle forced low, -1 for none
    int         gap;
    int         exp_kind;
    logic [7:0] exp_data;
  } vec_t;

  ev_t    evq[$];
  longint cyc = 0;
  longint t0  = 0;
  int     checks = 0;
  int     errors = 0;
  logic [7:0] last_wr = 8'h00;

  always @(posedge uart_clk) cyc <= cyc + 1;

  always @(negedge uart_clk) begin
    if (rif.rf_wrreq)  evq.push_back('{K_WR, rif.rf_data, cyc});
    if (rif.frame_err) evq.push_back('{K_FE, 8'h00, cyc});
    if (rif.overrun)   evq.push_back('{K_OV, 8'h00, cyc});
    if (rif.rf_wrreq || rif.frame_err || rif.overrun) begin
      checks++;
      if (int'(rif.rf_wrreq) + int'(rif.frame_err) + int'(rif.overrun) > 1) begin
        errors++;
        $display("FAIL exclusive pulses: got wr=%0b fe=%0b ov=%0b want at most one",
                 rif.rf_wrreq, rif.frame_err, rif.overrun);
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One expected event (or none) since the last check; queue is drained.
  task automatic chk_ev(input string name, input int kind, input logic [7:0] data, input bit chk_lat);
    chk({name, " events"}, evq.size(), (kind == K_NONE) ? 0 : 1);
    if (kind != K_NONE && evq.size() >= 1) begin
      chk({name, " kind"}, evq[0].kind, kind);
      if (kind == K_WR) chk({name, " data"}, evq[0].data, data);
      if (chk_lat) chk({name, " latency"}, evq[0].cyc - t0, LAT);
    end
    evq.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge uart_clk);
      uart_rxd = 1'b1;
    end
  endtask

  task automatic drive_level(input logic v, input int n);
    repeat (n) begin
      @(negedge uart_clk);
      uart_rxd = v;
    end
  endtask

  // Bit j occupies drive cycles floor(j*b4/4) .. floor((j+1)*b4/4)-1.
  task automatic drive_frame(input logic [7:0] d, input bit stop_ok, input int b4,
                             input int glitch, input int ncyc);
    int   j;
    logic v;
    for (int t = 0; t < 400; t++) begin
      j = (4*t + 3) / b4;
      if (j > 9 || (ncyc >= 0 && t >= ncyc)) break;
      @(negedge uart_clk);
      if (t == 0) t0 = cyc;
      v = (j == 0) ? 1'b0 : (j <= 8) ? d[j-1] : stop_ok;
      if (t == glitch) v = 1'b0;
      uart_rxd = v;
    end
  endtask

  // Frame-level reference: outcome depends only on the stop bit and rf_full.
  function automatic int model_kind(input bit stop_ok, input bit full);
    if (!stop_ok) return K_FE;
    if (full)     return K_OV;
    return K_WR;
  endfunction

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'h55, 64, 1'b1, 1'b0, -1, 32, K_WR, 8'h55};
    vecs[1] = '{8'h7E, 64, 1'b1, 1'b1, -1, 32, K_OV, 8'h00};
    vecs[2] = '{8'hB7, 64, 1'b1, 1'b0, 25, 32, K_WR, 8'hB7};
    vecs[3] = '{8'h5A, 68, 1'b1, 1'b0, -1, 32, K_WR, 8'h5A};
    vecs[4] = '{8'h81, 63, 1'b1, 1'b0, -1, 32, K_WR, 8'h81};
    vecs[5] = '{8'h12, 64, 1'b0, 1'b0, -1, 48, K_FE, 8'h00};
    vecs[6] = '{8'h34, 64, 1'b0, 1'b1, -1, 48, K_FE, 8'h00};
    vecs[7] = '{8'hE1, 66, 1'b1, 1'b0, -1, 32, K_WR, 8'hE1};

    rif.rf_full = 1'b0;
    repeat (3) @(negedge uart_clk);
    chk("reset outputs", {rif.rf_wrreq, rif.frame_err, rif.overrun, rif.rf_data}, 0);
    rst_n = 1'b1;
    idle(8);
    chk_ev("idle after reset", K_NONE, 8'h00, 1'b0);

    for (int i = 0; i < 8; i++) begin
      rif.rf_full = vecs[i].full;
      drive_frame(vecs[i].data, vecs[i].stop_ok, vecs[i].b4, vecs[i].glitch, -1);
      idle(vecs[i].gap);
      rif.rf_full = 1'b0;
      chk_ev($sformatf("vec%0d", i), vecs[i].exp_kind, vecs[i].exp_data, 1'b1);
      if (vecs[i].exp_kind == K_WR) last_wr = vecs[i].exp_data;
      chk($sformatf("vec%0d rf_data", i), rif.rf_data, last_wr);
    end

    // short low glitch on idle line, then a real frame
    drive_level(1'b0, 4);
    idle(24);
    chk_ev("glitch4", K_NONE, 8'h00, 1'b0);
    drive_frame(8'hA3, 1'b1, 64, -1, -1);
    idle(32);
    chk_ev("after glitch A3", K_WR, 8'hA3, 1'b1);
    last_wr = 8'hA3;

    // break: bad stop, line held low, then recovery
    drive_frame(8'hC3, 1'b0, 64, -1, -1);
    drive_level(1'b0, 40);
    idle(32);
    chk_ev("break C3", K_FE, 8'h00, 1'b0);
    chk("break rf_data", rif.rf_data, last_wr);
    drive_frame(8'h0F, 1'b1, 64, -1, -1);
    idle(32);
    chk_ev("after break 0F", K_WR, 8'h0F, 1'b1);
    last_wr = 8'h0F;

    // back-to-back frames with one stop bit at three rates
    foreach (vecs[i]) ;
    for (int r = 0; r < 3; r++) begin
      int b4;
      b4 = (r == 0) ? 64 : (r == 1) ? 68 : 63;
      drive_frame(8'h00, 1'b1, b4, -1, -1);
      drive_frame(8'hFF, 1'b1, b4, -1, -1);
      idle(32);
      chk($sformatf("b2b%0d count", b4), evq.size(), 2);
      if (evq.size() == 2) begin
        chk($sformatf("b2b%0d first", b4),  {evq[0].kind, evq[0].data}, {K_WR, 8'h00});
        chk($sformatf("b2b%0d second", b4), {evq[1].kind, evq[1].data}, {K_WR, 8'hFF});
      end
      evq.delete();
      last_wr = 8'hFF;
    end

    // reset in the middle of data bit 4 of 0x99
    drive_frame(8'h99, 1'b1, 64, -1, 88);
    @(negedge uart_clk);
    rst_n    = 1'b0;
    uart_rxd = 1'b1;
    repeat (3) @(negedge uart_clk);
    chk("mid-frame reset outputs", {rif.rf_wrreq, rif.frame_err, rif.overrun, rif.rf_data}, 0);
    rst_n = 1'b1;
    last_wr = 8'h00;
    idle(200);
    chk_ev("aborted 99", K_NONE, 8'h00, 1'b0);
    drive_frame(8'h3C, 1'b1, 64, -1, -1);
    idle(32);
    chk_ev("after reset 3C", K_WR, 8'h3C, 1'b1);
    last_wr = 8'h3C;
    chk("after reset rf_data", rif.rf_data, last_wr);

    // randomized frames against the frame-level model
    for (int n = 0; n < 40; n++) begin
      logic [7:0] d;
      int b4, kind;
      bit full, sok;
      d    = 8'($urandom);
      b4   = $urandom_range(68, 63);
      full = ($urandom_range(4, 0) == 0);
      sok  = ($urandom_range(6, 0) != 0);
      kind = model_kind(sok, full);
      rif.rf_full = full;
      drive_frame(d, sok, b4, -1, -1);
      idle(sok ? $urandom_range(20, 4) : 32);
      rif.rf_full = 1'b0;
      chk_ev($sformatf("rand%0d", n), kind, d, 1'b1);
      if (kind == K_WR) last_wr = d;
      chk($sformatf("rand%0d rf_data", n), rif.rf_data, last_wr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
